seq_multiplier: RTL and testbench

- Parametrised, iterative, multi-cycle integer multiplier. Successor to the single-cycle combinational multiplier in the ALU.
- Computes one radix-2 shift-add step per clock, in either signed or unsigned mode, and produces a WIDTH-bit result and 4-bit Flags.
- Uses a valid/ready handshake on both input and output, so the ALU/execute stage can stall on it.

---
 rtl/mul_pkg.sv | 16 +
 rtl/mul_flags.sv | 32 +++
 rtl/seq_multiplier.sv | 135 +++++++++++++
 tb/tb_seq_multiplier.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types for the iterative multiplier: FSM state encoding and flag bit positions.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/mul_flags.sv
// Combinational N/Z/C/V flag generation from a full 2W-bit product.
module mul_flags
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] prod,
    input  logic               s,
    output logic [3:0]         flags
);

    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             hi_nz;
    logic             not_sext;

    assign lo = prod[WIDTH-1:0];
    assign hi = prod[2*WIDTH-1:WIDTH];

    always_comb begin
        hi_nz    = |hi;
        // Signed overflow: the upper half must be a pure copy of the low word's sign bit
        not_sext = (hi != {WIDTH{lo[WIDTH-1]}});

        flags         = 4'b0000;
        flags[FLAG_N] = lo[WIDTH-1];
        flags[FLAG_Z] = (lo == '0);
        flags[FLAG_C] = hi_nz;
        flags[FLAG_V] = s ? not_sext : hi_nz;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier, one step per clock, signed/unsigned, valid/ready on both sides.
// Define MUL_HIGH_WORD_EN to expose the registered upper product word on OutHi.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic             S,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Out,
    output logic [3:0]       Flags
`ifdef MUL_HIGH_WORD_EN
    ,
    output logic [WIDTH-1:0] OutHi
`endif
);

    import mul_pkg::*;

    // state | meaning
    // IDLE  | ready for operands
    // CALC  | WIDTH shift-add steps on the magnitudes
    // FIX   | apply result sign, register Out/Flags
    // DONE  | result valid, wait for Out_Ready

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mul_state_t         state, state_nxt;
    logic               s_q;
    logic               sign_q;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    logic               accept;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [2*WIDTH-1:0] prod_fix;
    logic [3:0]         flags_c;

    assign In_Ready  = (state == IDLE);
    assign Out_Valid = (state == DONE);
    assign accept    = In_Valid && In_Ready;

    // Magnitudes held as W-bit unsigned so the most negative value maps onto itself
    assign mag1     = (S && In1[WIDTH-1]) ? -In1 : In1;
    assign mag2     = (S && In2[WIDTH-1]) ? -In2 : In2;
    assign prod_fix = sign_q ? -acc : acc;

    mul_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .prod  (prod_fix),
        .s     (s_q),
        .flags (flags_c)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = CALC;
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (Out_Ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s_q    <= 1'b0;
            sign_q <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            Out    <= '0;
            Flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        s_q    <= S;
                        sign_q <= (In1[WIDTH-1] ^ In2[WIDTH-1]) & S;
                        mcand  <= {{WIDTH{1'b0}}, mag1};
                        mplier <= mag2;
                        acc    <= '0;
                        cnt    <= CNT_W'(WIDTH - 1);
                    end
                end
                CALC: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    Out   <= prod_fix[WIDTH-1:0];
                    Flags <= flags_c;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MUL_HIGH_WORD_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            OutHi <= '0;
        end else if (state == FIX) begin
            OutHi <= prod_fix[2*WIDTH-1:WIDTH];
        end
    end
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH = 32.
module tb_seq_multiplier;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         In_Valid;
    logic         In_Ready;
    logic [W-1:0] In1;
    logic [W-1:0] In2;
    logic         S;
    logic         Out_Valid;
    logic         Out_Ready;
    logic [W-1:0] Out;
    logic [3:0]   Flags;
`ifdef MUL_HIGH_WORD_EN
    logic [W-1:0] OutHi;
`endif

    int checks = 0;
    int errors = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .In1       (In1),
        .In2       (In2),
        .S         (S),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out       (Out),
        .Flags     (Flags)
`ifdef MUL_HIGH_WORD_EN
        ,
        .OutHi     (OutHi)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands, take the accept edge, scramble inputs, then wait for Out_Valid.
    task automatic start_and_wait(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input string tag);
        int lat;
        @(negedge Clk);
        S = s; In1 = a; In2 = b; In_Valid = 1'b1;
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
        In1 = $urandom; In2 = $urandom; S = ~s;
        lat = 0;
        while (!Out_Valid && lat < 100) begin
            @(posedge Clk);
            lat++;
            #1;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd33);
    endtask

    task automatic check_result(input logic [W-1:0] eo, input logic [3:0] ef,
                                input logic [W-1:0] eh, input string tag);
        chk({tag, "_out"}, 64'(Out), 64'(eo));
        chk({tag, "_flags"}, 64'(Flags), 64'(ef));
`ifdef MUL_HIGH_WORD_EN
        chk({tag, "_outhi"}, 64'(OutHi), 64'(eh));
`else
        if (eh != eh) $display("unreachable");
`endif
    endtask

    task automatic consume(input string tag);
        @(negedge Clk);
        Out_Ready = 1'b1;
        @(posedge Clk);
        #1;
        Out_Ready = 1'b0;
        chk({tag, "_valid_drop"}, 64'(Out_Valid), 64'd0);
        chk({tag, "_ready_back"}, 64'(In_Ready), 64'd1);
    endtask

    task automatic op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] eo, input logic [3:0] ef, input logic [W-1:0] eh,
                      input string tag);
        start_and_wait(s, a, b, tag);
        check_result(eo, ef, eh, tag);
        consume(tag);
    endtask

    initial begin
        Rst = 1'b1; In_Valid = 1'b0; In1 = '0; In2 = '0; S = 1'b0; Out_Ready = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b0;
        chk("rst_in_ready", 64'(In_Ready), 64'd1);
        chk("rst_out_valid", 64'(Out_Valid), 64'd0);
        chk("rst_out", 64'(Out), 64'd0);
        chk("rst_flags", 64'(Flags), 64'd0);
`ifdef MUL_HIGH_WORD_EN
        chk("rst_outhi", 64'(OutHi), 64'd0);
`endif

        // Out_Ready high while idle does nothing
        Out_Ready = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Out_Ready = 1'b0;
        chk("idle_oready_valid", 64'(Out_Valid), 64'd0);
        chk("idle_oready_ready", 64'(In_Ready), 64'd1);

        op(1'b1, 32'd5, 32'd7, 32'd35, 4'b0000, 32'h0, "s_5x7");
        op(1'b1, 32'd1, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 4'b1010, 32'hFFFF_FFFF, "s_1xm5");
        op(1'b1, 32'd2147483647, 32'd1999999999, 32'h08CA_6C01, 4'b0011, 32'h3B9A_C9FF, "s_big");
        op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1001, 32'h0, "s_minxm1");
        op(1'b1, 32'd0, 32'd30, 32'd0, 4'b0100, 32'h0, "s_0x30");
        op(1'b0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 4'b1011, 32'h1, "u_ffx2");
        op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0011, 32'hFFFF_FFFE, "u_ffxff");

        // Stall in DONE with In_Valid asserted: nothing may move
        start_and_wait(1'b1, 32'hFFFF_FFFD, 32'd6, "stall");
        In_Valid = 1'b1; In1 = 32'd9; In2 = 32'd9; S = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            chk("stall_valid", 64'(Out_Valid), 64'd1);
            chk("stall_out", 64'(Out), 64'(32'hFFFF_FFEE));
            chk("stall_flags", 64'(Flags), 64'(4'b1010));
            chk("stall_in_ready", 64'(In_Ready), 64'd0);
        end
        In_Valid = 1'b0;
        consume("stall");
        op(1'b0, 32'd9, 32'd9, 32'd81, 4'b0000, 32'h0, "b2b");

        // Reset during CALC cycle 10 discards the operation
        @(negedge Clk);
        S = 1'b1; In1 = 32'd123; In2 = 32'd456; In_Valid = 1'b1;
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
        repeat (9) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        chk("abort_in_ready", 64'(In_Ready), 64'd1);
        chk("abort_out_valid", 64'(Out_Valid), 64'd0);
        chk("abort_flags", 64'(Flags), 64'd0);
        chk("abort_out", 64'(Out), 64'd0);
        op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'd42, 4'b0000, 32'h0, "post_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
